i2s_master: RTL and testbench
=============================

I2S_MASTER -- requirements
Module: i2s_master

Interface
REQ-001 Parameter WL, default 16: audio word length in bits; legal values 16, 20, 24.
REQ-002 Parameter CLK_DIV, default 4: BCLK half-period in clk cycles; legal values ≥ 2.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  run request; level sensitive.
REQ-006 aud_bclk  output  1  generated bit clock, registered.
REQ-007 aud_lrc  output  1  generated frame clock; 0 = left, 1 = right; registered.
REQ-008 aud_dacdat  output  1  serial playback data, registered.
REQ-009 aud_adcdat  input  1  serial record data from the codec.
REQ-010 dac_data  input  32  playback word; only dac_data[WL-1:0] is used, MSB at dac_data[WL-1].
REQ-011 adc_data  output  32  recorded word, right-aligned; upper 32-WL bits are 0.
REQ-012 rx_chan  output  1  channel of the current adc_data; 0 = left.
REQ-013 rx_done  output  1  one-clk pulse: adc_data and rx_chan are updated.
REQ-014 tx_done  output  1  one-clk pulse: dac_data has been latched, so the next word may be presented.

Function
REQ-015 The divider counts 0..CLK_DIV-1 in RUN and DRAIN; aud_bclk toggles on terminal count, giving BCLK = clk/(2·CLK_DIV).
REQ-016 Event "fall": aud_bclk goes 1→0. Event "rise": aud_bclk goes 0→1.
REQ-017 Slot counter pos (6 bits) advances by one on every fall and wraps 63→0, giving 64 BCLK per frame and 32 per channel.
REQ-018 aud_lrc = pos[5], updated in the same clk edge as the fall that sets pos.
REQ-019 At pos 0 and pos 32 (slot start), the block latches dac_data[WL-1:0] into the shift register and pulses tx_done for one clk.
REQ-020 I2S one-bit delay: at slot positions 1..WL, aud_dacdat drives the latched word MSB first, changing on the fall; at all other positions aud_dacdat = 0.
REQ-021 aud_adcdat is sampled on the rise at slot positions 1..WL, MSB first.
REQ-022 One clk after the rise that samples the WL-th bit, adc_data is updated, rx_chan is set to that slot's aud_lrc, and rx_done pulses.
REQ-023 FSM has three states.
- IDLE: aud_bclk = 0, aud_lrc = 0, aud_dacdat = 0, counters cleared.
- RUN: normal operation.
- DRAIN: en low; running until the frame completes.
REQ-024 IDLE→RUN when en = 1. The entry clk is treated as a fall at pos 0: dac_data is latched, tx_done pulses, and aud_lrc = 0. The first rise follows CLK_DIV clks later.
REQ-025 RUN→DRAIN when en = 0; en returning to 1 while in DRAIN returns to RUN with no interruption.
REQ-026 DRAIN→IDLE on the fall that wraps pos 63→0. No tx_done pulses on that edge; a frame is never truncated.
REQ-027 If tx_done and rx_done fall in the same clk, both pulse; the two paths are independent.
REQ-028 If dac_data changes between tx_done pulses, the change has no effect until the next slot start.

Reset
REQ-029 While rst_n = 0:
- FSM = IDLE.
- aud_bclk = 0, aud_lrc = 0, aud_dacdat = 0.
- adc_data = 0, rx_chan = 0, rx_done = 0, tx_done = 0.
- Divider, pos and shift registers = 0.
REQ-030 Reset mid-frame aborts immediately. After release, operation resumes per REQ-024 from a fresh left slot.

Structure
REQ-031 A shared package wm8978_pkg holds:
- SLOT_BITS = 32 and FRAME_BITS = 64.
- The FSM state type (IDLE/RUN/DRAIN).
- The legal-WL constants.
REQ-032 One sub-module, i2s_clk_gen, holds the divider and BCLK/LRC generation and pos, and exports one-clk fall/rise strobes. The top holds the FSM, shift registers and handshakes.
REQ-033 Illegal WL or CLK_DIV is rejected at elaboration.

Verification
REQ-034 Bench parameters: CLK_DIV = 2, WL = 16.
- BCLK period = 4 clk.
- tx_done spacing = 128 clk.
- Frame = 256 clk.
REQ-035 Serializer: dac_data = 0x0000A5F0.
- Left positions 1..16 show 1010 0101 1111 0000.
- Position 0 and positions 17..31 are 0.
REQ-036 Loopback: aud_adcdat tied to aud_dacdat, left 0x1234, right 0xBEEF.
- rx_done with adc_data = 0x00001234, rx_chan = 0.
- Then adc_data = 0x0000BEEF, rx_chan = 1, 128 clk later.
REQ-037 Drain: en dropped at left pos 10.
- The right slot completes.
- IDLE after pos 63, with aud_bclk held 0 and no further tx_done pulses.
REQ-038 Reset: rst_n asserted at right pos 20.
- All outputs 0 within that clk.
- After release with en = 1, tx_done pulses on the entry clk and aud_lrc = 0.
REQ-039 WL = 24, CLK_DIV = 3, dac_data = 0x00ABCDEF loopback → adc_data = 0x00ABCDEF.

Source files
------------

// File: rtl/wm8978_pkg.sv
// rtl/wm8978_pkg.sv - shared constants and types for the I2S master slice
package wm8978_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int POS_W      = $clog2(FRAME_BITS);
    localparam int SLOT_W     = $clog2(SLOT_BITS);

    localparam int WL_16 = 16;
    localparam int WL_20 = 20;
    localparam int WL_24 = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } i2s_state_t;

    function automatic bit wl_legal(input int wl);
        return (wl == WL_16) || (wl == WL_20) || (wl == WL_24);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - BCLK divider, slot position counter and LRC generation
module i2s_clk_gen
    import wm8978_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             aud_bclk,
    output logic             aud_lrc,
    output logic [POS_W-1:0] pos,
    output logic             fall,
    output logic             rise
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div;
    logic             tc;
    logic [POS_W-1:0] pos_inc;

    // Strobes are high during the clk that ends with the bclk edge
    always_comb begin
        tc      = run && (div == DIV_W'(CLK_DIV - 1));
        fall    = tc && aud_bclk;
        rise    = tc && !aud_bclk;
        pos_inc = pos + POS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            aud_bclk <= 1'b0;
            aud_lrc  <= 1'b0;
            pos      <= '0;
        end else if (!run) begin
            div      <= '0;
            aud_bclk <= 1'b0;
            aud_lrc  <= 1'b0;
            pos      <= '0;
        end else if (tc) begin
            div      <= '0;
            aud_bclk <= !aud_bclk;
            if (aud_bclk) begin
                pos     <= pos_inc;
                aud_lrc <= pos_inc[POS_W-1];
            end
        end else begin
            div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_master.sv
// rtl/i2s_master.sv - I2S master: run/drain FSM, serializer and deserializer
module i2s_master
    import wm8978_pkg::*;
#(
    parameter int WL      = 16,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        aud_bclk,
    output logic        aud_lrc,
    output logic        aud_dacdat,
    input  logic        aud_adcdat,
    input  logic [31:0] dac_data,
    output logic [31:0] adc_data,
    output logic        rx_chan,
    output logic        rx_done,
    output logic        tx_done
);

    if (!wl_legal(WL) || (CLK_DIV < 2)) begin : g_param_check
        $error("i2s_master: illegal WL or CLK_DIV");
    end

    i2s_state_t        state;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  fall_pos;
    logic [SLOT_W-1:0] fall_slot;
    logic [SLOT_W-1:0] rise_slot;
    logic              fall;
    logic              rise;
    logic [WL-1:0]     tx_sr;
    logic [WL-1:0]     rx_sr;
    logic              rx_pend;
    logic              rx_pend_chan;
    logic              unused_dac_hi;

    assign unused_dac_hi = ^dac_data[31:WL];

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state != ST_IDLE),
        .aud_bclk (aud_bclk),
        .aud_lrc  (aud_lrc),
        .pos      (pos),
        .fall     (fall),
        .rise     (rise)
    );

    always_comb begin
        fall_pos  = pos + POS_W'(1);
        fall_slot = fall_pos[SLOT_W-1:0];
        rise_slot = pos[SLOT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            aud_dacdat   <= 1'b0;
            adc_data     <= '0;
            rx_chan      <= 1'b0;
            rx_done      <= 1'b0;
            tx_done      <= 1'b0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            rx_pend      <= 1'b0;
            rx_pend_chan <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            rx_done <= 1'b0;
            rx_pend <= 1'b0;
            if (rx_pend) begin
                adc_data <= 32'(rx_sr);
                rx_chan  <= rx_pend_chan;
                rx_done  <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    aud_dacdat <= 1'b0;
                    // Entry behaves like a fall onto pos 0 of a left slot
                    if (en) begin
                        state   <= ST_RUN;
                        tx_sr   <= dac_data[WL-1:0];
                        tx_done <= 1'b1;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (fall && (pos == '1) && (state == ST_DRAIN) && !en) begin
                        state      <= ST_IDLE;
                        aud_dacdat <= 1'b0;
                    end else begin
                        state <= en ? ST_RUN : ST_DRAIN;
                        if (fall) begin
                            if (fall_slot == '0) begin
                                tx_sr      <= dac_data[WL-1:0];
                                tx_done    <= 1'b1;
                                aud_dacdat <= 1'b0;
                            end else if (fall_slot <= SLOT_W'(WL)) begin
                                aud_dacdat <= tx_sr[WL-1];
                                tx_sr      <= {tx_sr[WL-2:0], 1'b0};
                            end else begin
                                aud_dacdat <= 1'b0;
                            end
                        end
                    end
                    if (rise && (rise_slot != '0) && (rise_slot <= SLOT_W'(WL))) begin
                        rx_sr <= {rx_sr[WL-2:0], aud_adcdat};
                        if (rise_slot == SLOT_W'(WL)) begin
                            rx_pend      <= 1'b1;
                            rx_pend_chan <= pos[POS_W-1];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_master.sv
// tb/tb_i2s_master.sv - scoreboard bench for i2s_master in loopback
module tb_i2s_master;

    localparam int DIV = 2;
    localparam int BP  = 2 * DIV;
    localparam int RX_OFS = 16 * BP + DIV + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en_b;
    logic [31:0] dac_data;
    logic [31:0] dac_b;
    logic        aud_bclk, aud_lrc, aud_dacdat, rx_chan, rx_done, tx_done;
    logic [31:0] adc_data;
    logic        bclk_b, lrc_b, dacdat_b, rx_chan_b, rx_done_b, tx_done_b;
    logic [31:0] adc_data_b;
    logic        b_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] sb_q[$];

    always #5 clk = ~clk;

    i2s_master #(.WL(16), .CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .aud_bclk   (aud_bclk),
        .aud_lrc    (aud_lrc),
        .aud_dacdat (aud_dacdat),
        .aud_adcdat (aud_dacdat),
        .dac_data   (dac_data),
        .adc_data   (adc_data),
        .rx_chan    (rx_chan),
        .rx_done    (rx_done),
        .tx_done    (tx_done)
    );

    i2s_master #(.WL(24), .CLK_DIV(3)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_b),
        .aud_bclk   (bclk_b),
        .aud_lrc    (lrc_b),
        .aud_dacdat (dacdat_b),
        .aud_adcdat (dacdat_b),
        .dac_data   (dac_b),
        .adc_data   (adc_data_b),
        .rx_chan    (rx_chan_b),
        .rx_done    (rx_done_b),
        .tx_done    (tx_done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Timing model, t counted in clks from the entry edge
    task automatic run_model(input int t, input bit running);
        bit eb, el, et, er;
        eb = running && ((t % BP) >= DIV);
        el = running && (((t / BP) % 64) >= 32);
        et = running && ((t % 128) == 0);
        er = running && ((t % 128) == RX_OFS);
        chk($sformatf("bclk@%0d", t), 32'(aud_bclk), 32'(eb));
        chk($sformatf("lrc@%0d", t), 32'(aud_lrc), 32'(el));
        chk($sformatf("tx_done@%0d", t), 32'(tx_done), 32'(et));
        chk($sformatf("rx_done@%0d", t), 32'(rx_done), 32'(er));
    endtask

    // Scoreboard: push on tx_done, pop on rx_done, present next word
    initial begin : sb_proc
        logic [16:0] e;
        logic [15:0] nw;
        logic [15:0] word_tbl [3] = '{16'h5A0F, 16'h1234, 16'hBEEF};
        logic        exp_chan;
        int          wi;
        exp_chan = 1'b0;
        wi       = 0;
        dac_data = {16'hFFFF, 16'hA5F0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                exp_chan = 1'b0;
            end else begin
                if (rx_done) begin
                    if (sb_q.size() == 0) begin
                        chk("rx_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rx_data", adc_data, {16'h0, e[15:0]});
                        chk("rx_chan", 32'(rx_chan), 32'(e[16]));
                    end
                end
                if (tx_done) begin
                    sb_q.push_back({exp_chan, dac_data[15:0]});
                    exp_chan = ~exp_chan;
                    nw = (wi < 3) ? word_tbl[wi[1:0]] : 16'($urandom_range(0, 65535));
                    wi++;
                    dac_data = {16'($urandom_range(0, 65535)), nw};
                end
            end
        end
    end

    initial begin : b_proc
        int got;
        got = 0;
        dac_b = 32'h00ABCDEF;
        for (int i = 0; i < 3000 && got < 2; i++) begin
            @(negedge clk);
            if (rx_done_b) begin
                chk("b_data", adc_data_b, 32'h00ABCDEF);
                chk("b_chan", 32'(rx_chan_b), 32'(got[0]));
                got++;
            end
        end
        chk("b_rx_count", 32'(got), 32'd2);
        b_done = 1'b1;
    end

    initial begin : main
        logic [15:0] w;
        int p;
        w     = 16'hA5F0;
        rst_n = 1'b0;
        en    = 1'b0;
        en_b  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bclk", 32'(aud_bclk), 32'd0);
        chk("rst_lrc", 32'(aud_lrc), 32'd0);
        chk("rst_dacdat", 32'(aud_dacdat), 32'd0);
        chk("rst_adc_data", adc_data, 32'd0);
        chk("rst_rx_chan", 32'(rx_chan), 32'd0);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_bclk", 32'(aud_bclk), 32'd0);
        en   = 1'b1;
        en_b = 1'b1;

        for (int t = 0; t < 900; t++) begin
            @(negedge clk);
            run_model(t, t < 768);
            if (t < 128 && (t % BP) == DIV) begin
                p = t / BP;
                chk($sformatf("dacdat_pos%0d", p), 32'(aud_dacdat),
                    32'((p >= 1 && p <= 16) ? w[16 - p] : 1'b0));
            end
            if (t == 553) en = 1'b0;
        end
        chk("drain_q_empty", 32'(sb_q.size()), 32'd0);

        en = 1'b1;
        for (int t = 0; t < 210; t++) begin
            @(negedge clk);
            run_model(t, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        chk("arst_bclk", 32'(aud_bclk), 32'd0);
        chk("arst_lrc", 32'(aud_lrc), 32'd0);
        chk("arst_dacdat", 32'(aud_dacdat), 32'd0);
        chk("arst_adc_data", adc_data, 32'd0);
        chk("arst_rx_chan", 32'(rx_chan), 32'd0);
        chk("arst_rx_done", 32'(rx_done), 32'd0);
        chk("arst_tx_done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("entry_tx_done", 32'(tx_done), 32'd1);
        chk("entry_lrc", 32'(aud_lrc), 32'd0);
        for (int t = 1; t < 300; t++) begin
            @(negedge clk);
            run_model(t, 1'b1);
        end

        for (int i = 0; i < 2000 && !b_done; i++) @(negedge clk);
        chk("b_done", 32'(b_done), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
